// File: rtl/serial_add_pkg.sv
// serial_add_pkg: state encoding and width helper shared by the bit-serial adder
package serial_add_pkg;
  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fulladd.sv
// fulladd: combinational 1-bit full adder cell
module fulladd (
  input  logic A_in,
  input  logic B_in,
  input  logic C_in,
  output logic S_out,
  output logic C_out
);
  assign S_out = A_in ^ B_in ^ C_in;
  assign C_out = (A_in & B_in) | (C_in & (A_in ^ B_in));
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit unsigned add over WIDTH cycles through one fulladd, LSB first
module bit_serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK_in,
  input  logic             RST_in,
  input  logic             START_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C_in,
  output logic             BUSY_out,
  output logic             DONE_out,
  output logic [WIDTH-1:0] S_out,
  output logic             C_out
);
  localparam int CW = clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] opa, opb, acc;
  logic [CW-1:0] cnt;
  logic cy, fa_s, fa_c, last, load, run;
  fulladd u_fa (
    .A_in (opa[0]),
    .B_in (opb[0]),
    .C_in (cy),
    .S_out(fa_s),
    .C_out(fa_c)
  );
  assign last = cnt == CW'(WIDTH - 1);
  assign run = state == ST_RUN;
  assign load = START_in && !run;
  assign BUSY_out = run;
  assign DONE_out = state == ST_DONE;
  always_comb begin
    state_nx = ST_IDLE;
    state_nx = run ? (last ? ST_DONE : ST_RUN) : (START_in ? ST_RUN : ST_IDLE);
  end
  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      state <= ST_IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      S_out <= '0;
      C_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        opa <= A_in;
        opb <= B_in;
        cy  <= C_in;
        acc <= '0;
        cnt <= '0;
      end else if (run) begin
        opa <= opa >> 1;
        opb <= opb >> 1;
        acc <= {fa_s, acc[WIDTH-1:1]};
        cy  <= fa_c;
        cnt <= cnt + 1'b1;
        if (last) begin
          S_out <= {fa_s, acc[WIDTH-1:1]};
          C_out <= fa_c;
        end
      end
    end
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: scoreboard-driven checks of the bit-serial adder at WIDTH=8
module tb_bit_serial_adder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, s;
  logic busy, done, c;
  int total = 0, bad = 0;
  logic [8:0] sb[$];
  bit_serial_adder #(.WIDTH(8)) dut (
    .CLK_in(clk), .RST_in(rst), .START_in(start), .A_in(a), .B_in(b), .C_in(cin),
    .BUSY_out(busy), .DONE_out(done), .S_out(s), .C_out(c)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input bit push);
    @(negedge clk);
    start = 1'b1; a = ai; b = bi; cin = ci;
    if (push) sb.push_back(9'(ai) + 9'(bi) + 9'(ci));
  endtask
  task automatic wait_result(input int exp_lat, input string nm);
    int n, bn;
    logic [7:0] ps;
    logic pc;
    bit stable;
    logic [8:0] e;
    n = 0; bn = int'(busy); ps = s; pc = c; stable = 1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
      bn += int'(busy);
      if (s !== ps || c !== pc) stable = 0;
    end
    total++;
    if (n !== exp_lat || !done) begin bad++; $display("FAIL %s latency: got %0d done=%b want %0d", nm, n, done, exp_lat); end
    total++;
    if (bn !== exp_lat) begin bad++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, bn, exp_lat); end
    total++;
    if (!stable) begin bad++; $display("FAIL %s partial_visible: outputs changed before done", nm); end
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL %s scoreboard_empty: got {c,s}=%h want entry", nm, {c, s}); end
    else begin
      e = sb.pop_front();
      if ({c, s} !== e) begin bad++; $display("FAIL %s result: got c=%b s=%h want c=%b s=%h", nm, c, s, e[8], e[7:0]); end
    end
  endtask
  task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input string nm);
    drive(ai, bi, ci, 1);
    @(negedge clk);
    start = 1'b0;
    wait_result(8, nm);
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s done_pulse: got done=%b busy=%b want 0 0", nm, done, busy); end
  endtask
  task automatic test_reset;
    #1;
    total++;
    if ({busy, done, c, s} !== 11'd0) begin bad++; $display("FAIL reset: got busy=%b done=%b c=%b s=%h want all 0", busy, done, c, s); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_zero;      do_op(8'h00, 8'h00, 1'b0, "zero"); endtask
  task automatic test_ripple;    do_op(8'hFF, 8'h01, 1'b0, "ripple"); endtask
  task automatic test_carry_in;
    do_op(8'hA5, 8'h5A, 1'b1, "cin1");
    do_op(8'hA5, 8'h5A, 1'b0, "cin0");
    do_op(8'hFF, 8'hFF, 1'b1, "max");
  endtask
  task automatic test_start_busy;
    drive(8'h3C, 8'h42, 1'b0, 1);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; a = 8'h11; b = 8'h11;
    @(negedge clk); start = 1'b0;
    wait_result(5, "start_busy");
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL start_busy idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask
  task automatic test_back_to_back;
    drive(8'h80, 8'h80, 1'b0, 1);
    @(negedge clk); a = 8'h01; b = 8'h02; cin = 1'b0;
    sb.push_back(9'h003);
    wait_result(8, "b2b_first");
    @(negedge clk); start = 1'b0;
    wait_result(8, "b2b_second");
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    int dn;
    drive(8'h12, 8'h34, 1'b1, 0);
    repeat (4) @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, c, s} !== 11'd0) begin bad++; $display("FAIL reset_mid: got busy=%b done=%b c=%b s=%h want all 0", busy, done, c, s); end
    @(negedge clk); rst = 1'b0;
    dn = 0;
    repeat (12) begin @(negedge clk); dn += int'(done) + int'(busy); end
    total++;
    if (dn !== 0) begin bad++; $display("FAIL reset_mid no_done: got %0d active cycles want 0", dn); end
    do_op(8'h7F, 8'h01, 1'b1, "after_reset");
  endtask
  initial begin
    test_reset;
    test_zero;
    test_ripple;
    test_carry_in;
    test_start_busy;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
